// File: rtl/hermes_buffer_pkg.sv
// Shared Hermes router types: port ids, input-buffer FSM states, size-field width.
package HermesPkg;
   localparam int NPORT         = 5;
   localparam int HERMES_SIZE_W = 16;

   typedef enum logic [2:0] {EAST, WEST, NORTH, SOUTH, LOCAL} hermes_port_t;

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_HEADER, S_SIZE, S_PAYLOAD
   } hermes_buffer_fsm_t;
endpackage

// File: rtl/hermes_buffer_fifo.sv
// Circular flit store for the Hermes input buffer; head flit is always presented on data_o.
module hermes_fifo #(
   parameter int FLIT_SIZE   = 32,
   parameter int BUFFER_SIZE = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 wr_i,
   input  logic [FLIT_SIZE-1:0] data_i,
   input  logic                 rd_i,
   output logic [FLIT_SIZE-1:0] data_o,
   output logic                 full_o,
   output logic                 empty_o
);
   localparam int PW = $clog2(BUFFER_SIZE);
   localparam logic [PW:0] DEPTH = (PW+1)'(BUFFER_SIZE);

   logic [FLIT_SIZE-1:0] mem_q [BUFFER_SIZE];
   logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [PW:0]          cnt_q;
   logic                 wr_en, rd_en;

   assign full_o  = (cnt_q == DEPTH);
   assign empty_o = (cnt_q == '0);
   assign wr_en   = wr_i && !full_o;
   assign rd_en   = rd_i && !empty_o;
   assign data_o  = mem_q[rd_ptr_q];

   // Storage is cleared on reset so data_o reads zero until the first write.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < BUFFER_SIZE; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (wr_en) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end
endmodule

// File: rtl/hermes_buffer.sv
// Hermes router input buffer: FIFO plus packet FSM (request, header, size, payload).
// Optional packet counter port pkt_cnt_o is enabled with HERMES_BUFFER_STATS_EN.
module hermes_buffer
   import HermesPkg::*;
#(
   parameter int FLIT_SIZE   = 32,
   parameter int BUFFER_SIZE = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 rx_i,
   input  logic [FLIT_SIZE-1:0] data_i,
   output logic                 credit_o,
   output logic                 tx_o,
   output logic [FLIT_SIZE-1:0] data_o,
   input  logic                 credit_i,
   output logic                 req_o,
   input  logic                 ack_i,
   output logic                 sending_o
`ifdef HERMES_BUFFER_STATS_EN
  ,output logic [31:0]          pkt_cnt_o
`endif
);
   hermes_buffer_fsm_t       state_q;
   logic [HERMES_SIZE_W-1:0] cnt_q;
   logic                     req_q, send_q;
   logic                     full, empty, xfer, pkt_done;

   hermes_fifo #(.FLIT_SIZE(FLIT_SIZE), .BUFFER_SIZE(BUFFER_SIZE)) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .wr_i    (rx_i),
      .data_i  (data_i),
      .rd_i    (xfer),
      .data_o  (data_o),
      .full_o  (full),
      .empty_o (empty)
   );

   assign credit_o  = !full;
   assign req_o     = req_q;
   assign sending_o = send_q;
   assign tx_o      = send_q && !empty;
   assign xfer      = tx_o && credit_i;
   // Last flit of a packet: a zero-length size flit or the final payload flit.
   assign pkt_done  = xfer && ((state_q == S_SIZE && data_o[HERMES_SIZE_W-1:0] == '0) ||
                               (state_q == S_PAYLOAD && cnt_q == HERMES_SIZE_W'(1)));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         send_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (!empty) begin
               state_q <= S_REQ;
               req_q   <= 1'b1;
            end
            S_REQ: if (ack_i) begin
               state_q <= S_HEADER;
               req_q   <= 1'b0;
               send_q  <= 1'b1;
            end
            S_HEADER: if (xfer) state_q <= S_SIZE;
            S_SIZE: if (xfer) begin
               cnt_q <= data_o[HERMES_SIZE_W-1:0];
               if (pkt_done) begin
                  state_q <= S_IDLE;
                  send_q  <= 1'b0;
               end else begin
                  state_q <= S_PAYLOAD;
               end
            end
            S_PAYLOAD: if (xfer) begin
               cnt_q <= cnt_q - 1'b1;
               if (pkt_done) begin
                  state_q <= S_IDLE;
                  send_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               req_q   <= 1'b0;
               send_q  <= 1'b0;
            end
         endcase
      end
   end

`ifdef HERMES_BUFFER_STATS_EN
   logic [31:0] pkt_cnt_q, pkt_cnt_d;

   assign pkt_cnt_d = pkt_done ? pkt_cnt_q + 32'd1 : pkt_cnt_q;
   assign pkt_cnt_o = pkt_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) pkt_cnt_q <= '0;
      else         pkt_cnt_q <= pkt_cnt_d;
   end
`endif
endmodule
